matrix_inverse_checker: RTL and testbench

Self-check block for the matrix inverse datapath. It is loaded with an original N×N fixed-point matrix A and a candidate inverse B. It computes A·B one element at a time on a single multiply-accumulate unit and compares each element against the identity within a tolerance. It sits beside `matrix_inverse_calculator` as its verifying counterpart and reports pass/fail, the error count and the first failing index.

---
 rtl/matrix_pkg.sv | 18 +
 rtl/fixed_mac.sv | 28 ++
 rtl/matrix_inverse_checker.sv | 176 +++++++++++++++++
 tb/tb_matrix_inverse_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and FSM encoding for the matrix inverse datapath
// (calculator and checker).
package matrix_pkg;

   localparam int N     = 3;
   localparam int W     = 16;
   localparam int FRAC  = 8;
   localparam int IDX_W = 4;
   localparam int ONE   = 1 << FRAC;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAC   = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fixed_mac.sv
// Signed WxW multiplier feeding a 2W+2 bit accumulator with synchronous clear.
module fixed_mac #(
   parameter int W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic signed [W-1:0]   a,
   input  logic signed [W-1:0]   b,
   output logic signed [2*W+1:0] acc
);

   logic signed [2*W-1:0] w_prod;
   logic signed [2*W+1:0] r_acc;

   assign w_prod = a * b;
   assign acc    = r_acc;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_acc <= '0;
      end else if (en) begin
         r_acc <= r_acc + {{2{w_prod[2*W-1]}}, w_prod};
      end
   end

endmodule

// File: rtl/matrix_inverse_checker.sv
// Verifies a candidate inverse B of A by forming A*B element by element on one
// MAC and comparing each element to the identity within TOL LSBs.
module matrix_inverse_checker #(
   parameter int N    = 3,
   parameter int W    = 16,
   parameter int FRAC = 8,
   parameter int TOL  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_en,
   input  logic         load_sel,
   input  logic [3:0]   load_addr,
   input  logic [W-1:0] load_data,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [3:0]   err_count,
   output logic [3:0]   first_err_idx,
   output logic [1:0]   dbg_state
);

   import matrix_pkg::*;

   localparam int AW = 2 * W + 2;
   localparam logic [IDX_W-1:0] NN    = IDX_W'(N * N);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
   localparam logic signed [AW-1:0] TOL_V = AW'(TOL);
   localparam logic signed [AW-1:0] ONE_V = AW'(ONE);

   state_t r_state, w_next;

   logic signed [W-1:0] r_a [N*N];
   logic signed [W-1:0] r_b [N*N];

   logic [IDX_W-1:0] r_i, r_j, r_k;
   logic [IDX_W-1:0] r_err_cnt, r_first_idx;
   logic             r_first_seen;
   logic             r_done, r_pass;
   logic [IDX_W-1:0] r_out_err, r_out_idx;

   logic [IDX_W-1:0] w_a_addr, w_b_addr, w_elem_idx;
   logic             w_mac_clr, w_mac_en, w_last, w_fail;
   logic signed [AW-1:0] w_acc, w_res, w_exp, w_diff, w_abs;

   assign w_a_addr   = IDX_W'(r_i * N + r_k);
   assign w_b_addr   = IDX_W'(r_k * N + r_j);
   assign w_elem_idx = IDX_W'(r_i * N + r_j);
   assign w_last     = (r_i == LAST) && (r_j == LAST);

   fixed_mac #(.W(W)) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (w_mac_clr),
      .en  (w_mac_en),
      .a   (r_a[w_a_addr]),
      .b   (r_b[w_b_addr]),
      .acc (w_acc)
   );

   // Result is floor(acc / 2^FRAC); the difference stays at accumulator width.
   assign w_res  = w_acc >>> FRAC;
   assign w_exp  = (r_i == r_j) ? ONE_V : '0;
   assign w_diff = w_res - w_exp;
   assign w_abs  = w_diff[AW-1] ? -w_diff : w_diff;
   assign w_fail = w_abs > TOL_V;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_mac_clr = 1'b0;
      w_mac_en  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next    = S_MAC;
               w_mac_clr = 1'b1;
            end
         end
         S_MAC: begin
            w_mac_en = 1'b1;
            if (r_k == LAST) w_next = S_CHECK;
         end
         S_CHECK: begin
            w_mac_clr = 1'b1;
            w_next    = w_last ? S_DONE : S_MAC;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Matrix storage is writable only while idle so a run sees stable operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < N * N; n++) begin
            r_a[n] <= '0;
            r_b[n] <= '0;
         end
      end else if (r_state == S_IDLE && load_en && load_addr < NN) begin
         if (load_sel) r_b[load_addr] <= load_data;
         else          r_a[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_i          <= '0;
         r_j          <= '0;
         r_k          <= '0;
         r_err_cnt    <= '0;
         r_first_idx  <= '0;
         r_first_seen <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_out_err    <= '0;
         r_out_idx    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_i          <= '0;
                  r_j          <= '0;
                  r_k          <= '0;
                  r_err_cnt    <= '0;
                  r_first_idx  <= '0;
                  r_first_seen <= 1'b0;
               end
            end
            S_MAC: begin
               r_k <= (r_k == LAST) ? '0 : r_k + 1'b1;
            end
            S_CHECK: begin
               r_k <= '0;
               if (w_fail) begin
                  r_err_cnt <= r_err_cnt + 1'b1;
                  if (!r_first_seen) begin
                     r_first_seen <= 1'b1;
                     r_first_idx  <= w_elem_idx;
                  end
               end
               if (r_j == LAST) begin
                  r_j <= '0;
                  r_i <= r_i + 1'b1;
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end
            S_DONE: begin
               r_done    <= 1'b1;
               r_pass    <= (r_err_cnt == '0);
               r_out_err <= r_err_cnt;
               r_out_idx <= r_first_seen ? r_first_idx : NN;
            end
            default: ;
         endcase
      end
   end

   assign busy          = (r_state != S_IDLE);
   assign done          = r_done;
   assign pass          = r_pass;
   assign err_count     = r_out_err;
   assign first_err_idx = r_out_idx;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_matrix_inverse_checker.sv
// Directed bench for matrix_inverse_checker: expected results are queued at
// start and compared by an independent monitor whenever done pulses.
module tb_matrix_inverse_checker;

   localparam int N = 3;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_en;
   logic         load_sel;
   logic [3:0]   load_addr;
   logic [W-1:0] load_data;
   logic         start;
   logic         busy, done, pass;
   logic [3:0]   err_count, first_err_idx;
   logic [1:0]   dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [8:0] exp_q[$];
   logic [8:0] mon_exp;
   int         mat [9];

   logic       cw_en = 1'b0;
   logic       cw_sel;
   logic [3:0] cw_addr;
   int         cw_data;

   always #5 clk = ~clk;

   matrix_inverse_checker #(.N(N), .W(W), .FRAC(8), .TOL(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .load_en       (load_en),
      .load_sel      (load_sel),
      .load_addr     (load_addr),
      .load_data     (load_data),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .dbg_state     (dbg_state)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic write_el(input logic sel, input int addr, input int data);
      load_en   = 1'b1;
      load_sel  = sel;
      load_addr = 4'(addr);
      load_data = 16'(data);
      @(posedge clk);
      #1 load_en = 1'b0;
   endtask

   task automatic load_mat(input logic sel);
      for (int n = 0; n < 9; n++) write_el(sel, n, mat[n]);
   endtask

   // poke: 0 none, 1 extra start mid-run, 2 write A[0] mid-run
   task automatic run_check(input string name, input logic p, input int e,
                            input int idx, input int poke);
      int n;
      bit seen;
      exp_q.push_back({p, 4'(e), 4'(idx)});
      start = 1'b1;
      if (cw_en) begin
         load_en   = 1'b1;
         load_sel  = cw_sel;
         load_addr = cw_addr;
         load_data = 16'(cw_data);
      end
      @(posedge clk);
      #1 start = 1'b0;
      load_en = 1'b0;
      cw_en   = 1'b0;
      chk({name, "_busy_after_start"}, int'(busy), 1);
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 200) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (n == 5 && poke == 1) start = 1'b1;
            if (n == 5 && poke == 2) begin
               load_en   = 1'b1;
               load_sel  = 1'b0;
               load_addr = 4'd0;
               load_data = 16'd999;
            end
            @(posedge clk);
            #1 start = 1'b0;
            load_en = 1'b0;
            n++;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_done required=done", name);
      end else begin
         chk({name, "_latency"}, n, 37);
         chk({name, "_busy_at_done"}, int'(busy), 0);
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (done) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done actual=done required=none");
         end else begin
            mon_exp = exp_q.pop_front();
            if ({pass, err_count, first_err_idx} !== mon_exp) begin
               failures++;
               $display("FAIL result actual=pass:%0d err:%0d idx:%0d required=pass:%0d err:%0d idx:%0d",
                        pass, err_count, first_err_idx, mon_exp[8], mon_exp[7:4], mon_exp[3:0]);
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      load_en   = 1'b0;
      load_sel  = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_err", int'(err_count), 0);
      chk("rst_idx", int'(first_err_idx), 0);
      chk("rst_state", int'(dbg_state), 0);

      // identity times identity
      mat = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
      load_mat(1'b0);
      load_mat(1'b1);
      run_check("ident", 1'b1, 0, 9, 0);

      // diagonal pair and the tolerance boundary on element (1,1)
      mat = '{512, 0, 0, 0, 1024, 0, 0, 0, 2048};
      load_mat(1'b0);
      mat = '{128, 0, 0, 0, 64, 0, 0, 0, 32};
      load_mat(1'b1);
      run_check("diag", 1'b1, 0, 9, 0);
      write_el(1'b1, 4, 65);
      run_check("tol_edge", 1'b1, 0, 9, 0);
      write_el(1'b1, 4, 66);
      run_check("tol_over", 1'b0, 1, 4, 0);
      cw_en = 1'b1; cw_sel = 1'b1; cw_addr = 4'd4; cw_data = 65;
      run_check("write_with_start", 1'b1, 0, 9, 0);

      // upper-triangular pair, then a wrong off-diagonal entry
      mat = '{256, 256, 0, 0, 256, 0, 0, 0, 256};
      load_mat(1'b0);
      mat = '{256, -256, 0, 0, 256, 0, 0, 0, 256};
      load_mat(1'b1);
      run_check("tri", 1'b1, 0, 9, 0);
      write_el(1'b1, 1, 256);
      run_check("tri_bad", 1'b0, 1, 1, 0);
      run_check("restart_ignored", 1'b0, 1, 1, 1);
      run_check("load_dropped", 1'b0, 1, 1, 2);
      run_check("load_dropped_after", 1'b0, 1, 1, 0);

      // negative results round toward minus infinity
      mat = '{128, 0, 0, 0, 256, 0, 0, 0, 256};
      load_mat(1'b0);
      mat = '{512, -9, 0, 0, 256, 0, 0, 0, 256};
      load_mat(1'b1);
      run_check("neg_floor_fail", 1'b0, 1, 1, 0);
      write_el(1'b1, 1, -7);
      run_check("neg_floor_pass", 1'b1, 0, 9, 0);

      // reset in the middle of a run
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_pass", int'(pass), 0);
      chk("midrst_err", int'(err_count), 0);
      chk("midrst_idx", int'(first_err_idx), 0);
      chk("midrst_state", int'(dbg_state), 0);
      repeat (45) @(posedge clk);
      #1;
      run_check("zero_arrays", 1'b0, 3, 0, 0);
      mat = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
      load_mat(1'b0);
      load_mat(1'b1);
      run_check("reload", 1'b1, 0, 9, 0);

      repeat (3) @(posedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
